chan_router: RTL
================

# chan_router

Routes the host channel interface produced by the FX2 comm block to `NUM_EP` independent byte-stream endpoints.
- Each endpoint owns one channel address.
- Per-endpoint read prefetch FIFOs and a shared write FIFO buffer all host-facing outputs, so nothing on the comm side depends combinationally on endpoint inputs.
- Sits between the comm block and application logic, in the same clock domain.

## Interface
- `NUM_EP`, 4: number of endpoints, 1..8.
- `BASE_CHAN`, 0: channel address of endpoint 0. Endpoint i owns address `BASE_CHAN+i`; `BASE_CHAN+NUM_EP-1` must be ≤ 127.

- `fx2Clk_in`  in  1  48MHz system clock. All logic on the rising edge.
- `reset_in`  in  1  Reset: synchronous and active-low.
- `chanAddr_in`  in  7  Selected channel, from the comm block. Changes only between transfers.
- `chanData_in`  in  8  Host-write data byte.
- `chanWrite_in`  in  1  Host-write strobe. Only asserted while `chanGotRoom_out`=1.
- `chanGotRoom_out`  out  1  Router can accept a host-write byte for the selected channel.
- `chanData_out`  out  8  Host-read data byte.
- `chanRead_in`  in  1  Host-read strobe. Pops the current byte. Only asserted while `chanGotData_out`=1.
- `chanGotData_out`  out  1  `chanData_out` is valid for the selected channel.
- `epWrData_out`  out  8·NUM_EP  Per-endpoint write data; endpoint i uses bits [8i+7:8i].
- `epWrValid_out`  out  NUM_EP  Write data valid.
- `epWrReady_in`  in  NUM_EP  Endpoint accepts write data.
- `epRdData_in`  in  8·NUM_EP  Per-endpoint read data.
- `epRdValid_in`  in  NUM_EP  Read data valid.
- `epRdReady_out`  out  NUM_EP  Router accepts read data.

## Operation
- **Decode:**
  - `hit` = `chanAddr_in` lies in [`BASE_CHAN`, `BASE_CHAN+NUM_EP-1`].
  - `idx` = `chanAddr_in - BASE_CHAN`, truncated to clog2(NUM_EP) bits; minimum 1 bit.
- **Write path:**
  - One shared FIFO, depth 4, entries {idx, data}.
  - Push on `chanWrite_in & hit`.
  - `chanGotRoom_out` = (wrCount < 4) when `hit`; 1 when unmapped. Unmapped writes are discarded.
  - The head entry drives `epWrValid_out[head.idx]` and `epWrData_out` of that endpoint. All other valids are 0.
  - Pop on `epWrReady_in[head.idx]`.
  - Strictly in-order: the head blocks later entries even if they target other endpoints.
- **Read path:**
  - One FIFO per endpoint, depth 2.
  - `epRdReady_out[i]` = (rdCount[i] < 2). Push on `epRdValid_in[i] & epRdReady_out[i]`.
  - On a hit: `chanGotData_out` = (rdCount[idx] ≠ 0) and `chanData_out` = head of FIFO idx. Pop on `chanRead_in`.
  - When unmapped: `chanGotData_out`=1, `chanData_out`=8'h00, and `chanRead_in` has no effect.
  - When the host idles, each endpoint FIFO prefetches up to 2 bytes independently.
  - Changing `chanAddr_in` never flushes buffered bytes; they stay for the next access to that channel.
- **Registering:** host-facing outputs are functions only of FIFO state registers and `chanAddr_in`. There is no path from `ep*_in` to `chan*_out`.
- **Simultaneous push and pop** on the same FIFO in the same cycle: the count is unchanged and both take effect. When full, a same-cycle pop does not open room: room is computed from the registered count.
- **Reset** (`reset_in`=0 at an edge, including mid-transfer):
  - All FIFOs are emptied and buffered bytes are lost.
  - While `reset_in`=0, outputs are forced to: `chanGotRoom_out`=0, `chanGotData_out`=0, `chanData_out`=0, `epWrValid_out`=0, `epRdReady_out`=0, `epWrData_out`=0.
  - Strobes seen while in reset are ignored.

## Timing
- Host write accepted at edge t → `epWrValid_out` high during cycle t+1, when the FIFO was empty.
- Endpoint read byte accepted at edge t → `chanGotData_out` high during cycle t+1, when the channel is selected and its FIFO was empty.
- Sustained throughput: 1 byte/cycle in each direction when the far side is always ready.
- First cycle after reset release: `chanGotRoom_out`=1 and `epRdReady_out`=all ones; `chanGotData_out`=0 for mapped channels.
- Counters: wrCount is 3 bits (0..4); rdCount[i] is 2 bits (0..2). Pointers wrap modulo depth.

## Structure
- Shared package `chan_router_pkg`:
  - `WR_FIFO_DEPTH`=4
  - `RD_FIFO_DEPTH`=2
  - `UNMAPPED_READ_BYTE`=8'h00
  - `clog2` helper function
- Sub-module `chan_fifo`:
  - Parameters: WIDTH, DEPTH.
  - Synchronous active-low reset.
  - Ports: push, pop, data, count, registered full/empty.
  - Instantiated once for the write path (WIDTH = idx bits + 8) and NUM_EP times for the read paths (WIDTH 8).
- The top level holds only decode, muxing and output gating.

## Test plan
- Write 5 bytes 0x11..0x15 to chan 1 with `epWrReady_in[1]`=0 → `chanGotRoom_out` drops after the 4th byte. Raising ready → endpoint 1 receives 0x11..0x14 in order on consecutive cycles.
- Endpoint 2 presents 0xA0,0xA1,0xA2 with the host idle → `epRdReady_out[2]`=0 after 2 bytes. Select chan 2 and read 3 bytes → host gets 0xA0,0xA1,0xA2.
- Prefetch 0x55 on chan 0, switch to chan 3, read, then return to chan 0 → 0x55 is still delivered.
- Select chan 9 with `BASE_CHAN`=0, `NUM_EP`=4 → `chanGotData_out`=1 with data 0x00. Writes are discarded and no `epWrValid_out` fires.
- Write FIFO full, `epWrReady_in` high, `chanWrite_in` attempted in the same cycle → `chanGotRoom_out` stays 0 that cycle and rises next cycle.
- Assert `reset_in`=0 with 3 bytes buffered mid-transfer → all outputs are 0 during reset. After release the FIFOs are empty and `chanGotData_out`=0 on chan 0.

Source files
------------

// File: rtl/chan_router_pkg.sv
// Shared constants and helpers for the channel router and its FIFOs.
package chan_router_pkg;

  localparam int         WR_FIFO_DEPTH      = 4;
  localparam int         RD_FIFO_DEPTH      = 2;
  localparam logic [7:0] UNMAPPED_READ_BYTE = 8'h00;

  // Ceiling log2; returns 0 for n <= 1.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((32'sd1 << r) < n) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/chan_router_if.sv
// Host channel bus plus per-endpoint byte streams seen by the router.
interface chan_router_if #(
  parameter int NUM_EP = 4
);

  logic [6:0]          chanAddr_in;
  logic [7:0]          chanData_in;
  logic                chanWrite_in;
  logic                chanGotRoom_out;
  logic [7:0]          chanData_out;
  logic                chanRead_in;
  logic                chanGotData_out;
  logic [8*NUM_EP-1:0] epWrData_out;
  logic [NUM_EP-1:0]   epWrValid_out;
  logic [NUM_EP-1:0]   epWrReady_in;
  logic [8*NUM_EP-1:0] epRdData_in;
  logic [NUM_EP-1:0]   epRdValid_in;
  logic [NUM_EP-1:0]   epRdReady_out;

  // Router side.
  modport slave (
    input  chanAddr_in, chanData_in, chanWrite_in, chanRead_in,
    input  epWrReady_in, epRdData_in, epRdValid_in,
    output chanGotRoom_out, chanData_out, chanGotData_out,
    output epWrData_out, epWrValid_out, epRdReady_out
  );

  // Comm block and endpoints side.
  modport master (
    output chanAddr_in, chanData_in, chanWrite_in, chanRead_in,
    output epWrReady_in, epRdData_in, epRdValid_in,
    input  chanGotRoom_out, chanData_out, chanGotData_out,
    input  epWrData_out, epWrValid_out, epRdReady_out
  );

endinterface

// File: rtl/chan_fifo.sv
// Small synchronous FIFO with registered count/full/empty flags.
// Push while full and pop while empty are ignored.
module chan_fifo
  import chan_router_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  localparam int CNT_W = clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? clog2(DEPTH) : 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             do_push_s, do_pop_s;

  // Pointer advance that wraps modulo DEPTH.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return {PTR_W{1'b0}};
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  // Next-state for pointers, occupancy and flags.
  always_comb begin
    do_push_s = push_i & ~full_q;
    do_pop_s  = pop_i & ~empty_q;
    wr_ptr_d  = do_push_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d  = do_pop_s ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == CNT_W'(DEPTH));
    empty_d = (count_d == {CNT_W{1'b0}});
  end

  // State and storage registers; reset empties the FIFO.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      if (do_push_s) begin
        mem_q[wr_ptr_q] <= data_i;
      end
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/chan_router.sv
// Routes the FX2 host channel bus to NUM_EP byte-stream endpoints.
// Host-facing outputs depend only on FIFO registers, chanAddr_in and reset.
module chan_router
  import chan_router_pkg::*;
#(
  parameter int NUM_EP    = 4,
  parameter int BASE_CHAN = 0
) (
  input logic          fx2Clk_in,
  input logic          reset_in,
  chan_router_if.slave bus
);

  localparam int IDX_W    = (clog2(NUM_EP) < 1) ? 1 : clog2(NUM_EP);
  localparam int WR_W     = IDX_W + 8;
  localparam int WR_CNT_W = clog2(WR_FIFO_DEPTH + 1);
  localparam int RD_CNT_W = clog2(RD_FIFO_DEPTH + 1);

  logic [7:0]          addr_off_s;
  logic                hit_s;
  logic [IDX_W-1:0]    idx_s;

  logic                wr_push_s, wr_pop_s;
  logic [WR_W-1:0]     wr_din_s, wr_head_s;
  logic [IDX_W-1:0]    wr_head_idx_s;
  logic [WR_CNT_W-1:0] wr_count_s;
  logic                wr_full_s, wr_empty_s;

  logic [NUM_EP-1:0]   rd_push_s, rd_pop_s;
  logic [7:0]          rd_head_s  [NUM_EP];
  logic [RD_CNT_W-1:0] rd_count_s [NUM_EP];
  logic [NUM_EP-1:0]   rd_full_s, rd_empty_s;

  // Channel address decode; addresses below BASE_CHAN wrap and miss.
  always_comb begin
    addr_off_s = {1'b0, bus.chanAddr_in} - 8'(BASE_CHAN);
    hit_s      = ({1'b0, bus.chanAddr_in} >= 8'(BASE_CHAN)) && (addr_off_s < 8'(NUM_EP));
    idx_s      = addr_off_s[IDX_W-1:0];
  end

  chan_fifo #(.WIDTH(WR_W), .DEPTH(WR_FIFO_DEPTH)) u_wr_fifo (
    .clk_i   (fx2Clk_in),
    .rst_n_i (reset_in),
    .push_i  (wr_push_s),
    .pop_i   (wr_pop_s),
    .data_i  (wr_din_s),
    .data_o  (wr_head_s),
    .count_o (wr_count_s),
    .full_o  (wr_full_s),
    .empty_o (wr_empty_s)
  );

  for (genvar g = 0; g < NUM_EP; g++) begin : g_rd
    chan_fifo #(.WIDTH(8), .DEPTH(RD_FIFO_DEPTH)) u_rd_fifo (
      .clk_i   (fx2Clk_in),
      .rst_n_i (reset_in),
      .push_i  (rd_push_s[g]),
      .pop_i   (rd_pop_s[g]),
      .data_i  (bus.epRdData_in[8*g +: 8]),
      .data_o  (rd_head_s[g]),
      .count_o (rd_count_s[g]),
      .full_o  (rd_full_s[g]),
      .empty_o (rd_empty_s[g])
    );
  end

  assign wr_head_idx_s = wr_head_s[WR_W-1:8];

  // FIFO strobes, endpoint steering and host output muxing, all forced idle in reset.
  always_comb begin
    wr_din_s             = {idx_s, bus.chanData_in};
    wr_push_s            = 1'b0;
    wr_pop_s             = 1'b0;
    rd_push_s            = {NUM_EP{1'b0}};
    rd_pop_s             = {NUM_EP{1'b0}};
    bus.epWrValid_out    = {NUM_EP{1'b0}};
    bus.epWrData_out     = {(8*NUM_EP){1'b0}};
    bus.epRdReady_out    = {NUM_EP{1'b0}};
    bus.chanGotRoom_out  = 1'b0;
    bus.chanGotData_out  = 1'b0;
    bus.chanData_out     = 8'h00;
    if (reset_in) begin
      wr_push_s = bus.chanWrite_in & hit_s & ~wr_full_s;
      for (int i = 0; i < NUM_EP; i++) begin
        // Only the head entry is presented; later entries wait behind it.
        if (!wr_empty_s && (wr_head_idx_s == IDX_W'(i))) begin
          bus.epWrValid_out[i]       = 1'b1;
          bus.epWrData_out[8*i +: 8] = wr_head_s[7:0];
          wr_pop_s                   = bus.epWrReady_in[i];
        end else begin
          bus.epWrValid_out[i]       = 1'b0;
        end
        bus.epRdReady_out[i] = ~rd_full_s[i];
        rd_push_s[i]         = bus.epRdValid_in[i] & ~rd_full_s[i];
        rd_pop_s[i]          = hit_s & (idx_s == IDX_W'(i)) & bus.chanRead_in & ~rd_empty_s[i];
      end
      if (hit_s) begin
        bus.chanGotRoom_out = (wr_count_s < WR_CNT_W'(WR_FIFO_DEPTH));
        bus.chanGotData_out = (rd_count_s[idx_s] != {RD_CNT_W{1'b0}});
        bus.chanData_out    = rd_head_s[idx_s];
      end else begin
        // Unmapped channels swallow writes and read as a constant byte.
        bus.chanGotRoom_out = 1'b1;
        bus.chanGotData_out = 1'b1;
        bus.chanData_out    = UNMAPPED_READ_BYTE;
      end
    end else begin
      wr_push_s = 1'b0;
    end
  end

endmodule
